// File: rtl/softmax_tile_feeder.sv
// Packs quantized attention scores into NUM-wide tiles, drives the softmax engine
// with running max/exp-sum carried across a row, and hands results downstream.
module softmax_tile_feeder #(
   parameter int D_W   = 8,
   parameter int NUM   = 16,
   parameter int IN_W  = 16,
   parameter int SHIFT = 3
) (
   input  logic                 I_CLK,
   input  logic                 I_RST,
   input  logic                 I_SCORE_VLD,
   input  logic [IN_W-1:0]      I_SCORE,
   input  logic                 I_ROW_FIRST,
   output logic                 O_SCORE_RDY,
   output logic                 O_SM_START,
   output logic [D_W*NUM-1:0]   O_SM_DATA,
   output logic [D_W-1:0]       O_SM_X_MAX,
   output logic [15:0]          O_SM_EXP_SUM,
   input  logic                 I_SM_VLD,
   input  logic [D_W*NUM-1:0]   I_SM_DATA,
   input  logic [D_W-1:0]       I_SM_X_MAX,
   input  logic [15:0]          I_SM_EXP_SUM,
   output logic                 O_TILE_VLD,
   output logic [D_W*NUM-1:0]   O_TILE_DATA,
   output logic [D_W-1:0]       O_TILE_X_MAX,
   output logic [15:0]          O_TILE_EXP_SUM,
   output logic                 O_TILE_ROW_FIRST,
   input  logic                 I_TILE_RDY
);

   localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [1:0] S_FILL = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;
   localparam logic [D_W-1:0] NEG_MAX = {1'b1, {(D_W-1){1'b0}}};
   localparam logic [D_W-1:0] POS_MAX = {1'b0, {(D_W-1){1'b1}}};
   localparam logic [IN_W:0]  RND     = {{IN_W{1'b0}}, 1'b1} << (SHIFT-1);

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 row_first_q, row_first_d;
   logic                 run_q, run_d;
   logic [D_W*NUM-1:0]   sm_data_q, sm_data_d;
   logic [D_W-1:0]       run_max_q, run_max_d;
   logic [15:0]          run_sum_q, run_sum_d;
   logic                 tile_vld_q, tile_vld_d;
   logic [D_W*NUM-1:0]   tile_data_q, tile_data_d;
   logic [D_W-1:0]       tile_max_q, tile_max_d;
   logic [15:0]          tile_sum_q, tile_sum_d;
   logic                 tile_rf_q, tile_rf_d;

   logic signed [IN_W:0] rnd_sum, rnd_shr;
   logic                 ovf;
   logic [D_W-1:0]       q_sat;

   // Extra headroom bit keeps the rounding add from wrapping at +full-scale.
   always_comb begin
      rnd_sum = $signed({I_SCORE[IN_W-1], I_SCORE} + RND);
      rnd_shr = rnd_sum >>> SHIFT;
      ovf     = ~((&rnd_shr[IN_W:D_W-1]) | ~(|rnd_shr[IN_W:D_W-1]));
      q_sat   = ovf ? (rnd_shr[IN_W] ? NEG_MAX : POS_MAX) : rnd_shr[D_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_first_d = row_first_q;
      run_d       = run_q;
      sm_data_d   = sm_data_q;
      run_max_d   = run_max_q;
      run_sum_d   = run_sum_q;
      tile_vld_d  = tile_vld_q;
      tile_data_d = tile_data_q;
      tile_max_d  = tile_max_q;
      tile_sum_d  = tile_sum_q;
      tile_rf_d   = tile_rf_q;
      case (state_q)
         S_FILL: begin
            if (I_SCORE_VLD) begin
               sm_data_d[cnt_q*D_W +: D_W] = q_sat;
               if (cnt_q == '0) row_first_d = I_ROW_FIRST;
               if (cnt_q == CW'(NUM-1)) begin
                  cnt_d   = '0;
                  run_d   = 1'b1;
                  state_d = S_RUN;
               end else begin
                  cnt_d = CW'(cnt_q + 1'b1);
               end
            end
         end
         S_RUN: begin
            if (I_SM_VLD) begin
               tile_data_d = I_SM_DATA;
               tile_max_d  = I_SM_X_MAX;
               tile_sum_d  = I_SM_EXP_SUM;
               tile_rf_d   = row_first_q;
               tile_vld_d  = 1'b1;
               run_max_d   = I_SM_X_MAX;
               run_sum_d   = I_SM_EXP_SUM;
               run_d       = 1'b0;
               state_d     = S_OUT;
            end
         end
         S_OUT: begin
            if (I_TILE_RDY) begin
               tile_vld_d = 1'b0;
               state_d    = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q     <= S_FILL;
         cnt_q       <= '0;
         row_first_q <= 1'b0;
         run_q       <= 1'b0;
         sm_data_q   <= '0;
         run_max_q   <= NEG_MAX;
         run_sum_q   <= '0;
         tile_vld_q  <= 1'b0;
         tile_data_q <= '0;
         tile_max_q  <= '0;
         tile_sum_q  <= '0;
         tile_rf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_first_q <= row_first_d;
         run_q       <= run_d;
         sm_data_q   <= sm_data_d;
         run_max_q   <= run_max_d;
         run_sum_q   <= run_sum_d;
         tile_vld_q  <= tile_vld_d;
         tile_data_q <= tile_data_d;
         tile_max_q  <= tile_max_d;
         tile_sum_q  <= tile_sum_d;
         tile_rf_q   <= tile_rf_d;
      end
   end

   // Start drops in the pulse cycle itself so the engine never re-arms.
   assign O_SCORE_RDY      = (state_q == S_FILL);
   assign O_SM_START       = run_q & ~I_SM_VLD;
   assign O_SM_DATA        = sm_data_q;
   assign O_SM_X_MAX       = row_first_q ? NEG_MAX : run_max_q;
   assign O_SM_EXP_SUM     = row_first_q ? 16'h0000 : run_sum_q;
   assign O_TILE_VLD       = tile_vld_q;
   assign O_TILE_DATA      = tile_data_q;
   assign O_TILE_X_MAX     = tile_max_q;
   assign O_TILE_EXP_SUM   = tile_sum_q;
   assign O_TILE_ROW_FIRST = tile_rf_q;

endmodule

// File: doc/softmax_tile_feeder.md
Name: softmax_tile_feeder

Overview:
- Upstream stage of the 8-bit safe_softmax tile engine in the attention datapath.
- Collects a stream of wide signed attention scores, one per beat. Each score is scaled by 2^-SHIFT, rounded and saturated to signed D_W. NUM scores are packed into one tile.
- Drives the softmax start/data/running-statistics inputs and carries the running max and exp-sum across the tiles of a row.
- Captures each softmax result and presents it downstream with a valid/ready handshake.

Parameters:
- D_W, 8, softmax element width (signed).
- NUM, 16, scores per tile.
- IN_W, 16, input score width (signed).
- SHIFT, 3, right-shift scale (1/sqrt(d_k) approximation); legal range 1..IN_W-D_W.

Ports:
- I_CLK  in  1  clock.
- I_RST  in  1  synchronous active-high reset.
- I_SCORE_VLD  in  1  input score valid.
- I_SCORE  in  IN_W  signed score.
- I_ROW_FIRST  in  1  qualifies the beat that fills slot 0; 1 = tile starts a new row.
- O_SCORE_RDY  out  1  feeder can accept a score.
- O_SM_START  out  1  start to softmax; held high for the whole computation.
- O_SM_DATA  out  D_W x NUM  packed quantized tile.
- O_SM_X_MAX  out  D_W  running max presented to softmax.
- O_SM_EXP_SUM  out  16  running exp-sum presented to softmax.
- I_SM_VLD  in  1  softmax one-cycle result pulse.
- I_SM_DATA  in  D_W x NUM  softmax result.
- I_SM_X_MAX  in  D_W  updated max from softmax.
- I_SM_EXP_SUM  in  16  updated exp-sum from softmax.
- O_TILE_VLD  out  1  result tile valid.
- O_TILE_DATA  out  D_W x NUM  captured result.
- O_TILE_X_MAX  out  D_W  max after this tile.
- O_TILE_EXP_SUM  out  16  exp-sum after this tile.
- O_TILE_ROW_FIRST  out  1  row-first flag of this tile.
- I_TILE_RDY  in  1  downstream accepts the tile.

Behaviour:
- Clock and reset: one clock I_CLK; reset I_RST is synchronous, active-high.
- On reset, all of the following go to 0: state = S_FILL, slot count, O_SM_DATA, O_TILE_DATA, O_TILE_X_MAX, O_TILE_EXP_SUM, O_TILE_VLD, O_TILE_ROW_FIRST, run_sum and O_SM_START.
- Also on reset: run_max = 8'h80 (most-negative signed value) and O_SCORE_RDY = 1.
- Quantization, one beat per accepted score:
  - q = (I_SCORE + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits (round half up).
  - q is saturated to [-2^(D_W-1), 2^(D_W-1)-1].
  - q is written to slot cnt.
- States:
  - S_FILL:
    - O_SCORE_RDY = 1; accept on I_SCORE_VLD & O_SCORE_RDY; cnt increments.
    - On accept at cnt = 0, latch I_ROW_FIRST as row_first.
    - Accept at cnt = NUM-1: cnt wraps to 0 and the state goes to S_RUN on the next edge.
  - S_RUN:
    - O_SCORE_RDY = 0; run_q = 1.
    - O_SM_START = run_q & ~I_SM_VLD (combinational), so start is already low in the pulse cycle and the engine cannot re-enter its add state.
    - O_SM_DATA, O_SM_X_MAX and O_SM_EXP_SUM are held stable through the I_SM_VLD cycle.
    - If row_first = 1, O_SM_X_MAX = 8'h80 and O_SM_EXP_SUM = 0; otherwise they are run_max and run_sum.
    - On I_SM_VLD, latch into the tile outputs: I_SM_DATA -> O_TILE_DATA, I_SM_X_MAX -> O_TILE_X_MAX, I_SM_EXP_SUM -> O_TILE_EXP_SUM, row_first -> O_TILE_ROW_FIRST.
    - Also on I_SM_VLD, update run_max = I_SM_X_MAX and run_sum = I_SM_EXP_SUM; then go to S_OUT.
  - S_OUT:
    - O_TILE_VLD = 1; tile outputs are stable until I_TILE_RDY; O_SCORE_RDY = 0.
    - On I_TILE_RDY, go to S_FILL with O_TILE_VLD = 0 on the next cycle.
- No overlap: the next tile is not filled until the current tile is handed off.
- Latency:
  - From the last score accepted to O_SM_START high: 1 cycle.
  - From I_SM_VLD to O_TILE_VLD: 1 cycle.
  - Softmax compute time is variable; the feeder simply waits for the pulse.
- Boundaries:
  - I_SM_VLD outside S_RUN is ignored.
  - I_SCORE_VLD while O_SCORE_RDY = 0 is ignored (not stored).
  - I_ROW_FIRST on beats other than slot 0 is ignored.
  - I_RST asserted in any state aborts immediately. O_SM_START is low on the cycle after the reset edge, the partial tile is discarded and the running stats are cleared.

Test Plan:
- Quantization, SHIFT=3: scores 20, -20, 4, 16'h7FFF, 16'h8000 -> slot values 3, -2, 1, 127, -128 on O_SM_DATA when O_SM_START rises.
- First tile (ROW_FIRST = 1), 16 scores accepted back-to-back -> O_SM_START high 1 cycle after the 16th accept, O_SM_X_MAX = 8'h80, O_SM_EXP_SUM = 0.
- Engine model pulses I_SM_VLD with X_MAX = 8'h12, EXP_SUM = 16'h2A00 -> O_SM_START is low in the same cycle. Next cycle O_TILE_VLD = 1 with those values. The following tile (ROW_FIRST = 0) presents O_SM_X_MAX = 8'h12 and O_SM_EXP_SUM = 16'h2A00.
- Backpressure: I_TILE_RDY = 0 for 5 cycles -> O_TILE_VLD and the tile outputs are stable, O_SCORE_RDY = 0, offered scores are dropped. On I_TILE_RDY = 1, O_SCORE_RDY = 1 on the next cycle.
- Gapped input: I_SCORE_VLD toggled every other cycle -> exactly 16 accepts per tile; slot order matches arrival order.
- Reset in S_RUN, 3 cycles after start -> next cycle O_SM_START = 0, O_SCORE_RDY = 1, run_max = 8'h80. A new row then starts cleanly.
